// File: rtl/adc_reader_pkg.sv
// Shared types and constants for the ADC sample reader: FSM states,
// CSR address map and the packed FIFO entry layout.
package adc_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_ENIRQ    = 3'd2,
        ST_WAIT_IRQ = 3'd3,
        ST_READ     = 3'd4,
        ST_CAPTURE  = 3'd5,
        ST_CLEAR    = 3'd6,
        ST_STOP     = 3'd7
    } adc_state_e;

    localparam logic       SEQ_CMD = 1'b0;
    localparam logic [6:0] IER     = 7'h40;
    localparam logic [6:0] ISR     = 7'h41;

    typedef struct packed {
        logic [5:0]  slot;
        logic [11:0] data;
    } sample_entry_t;

endpackage

// File: rtl/adc_reader_fifo.sv
// Synchronous register-based FIFO with occupancy count and full/empty flags.
// Storage is reset so the head output reads zero while empty after reset.
module adc_reader_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok, pop_ok;

    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Gating by flags keeps the count exact on push+pop while full or empty.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_ok) rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
            else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/adc_sample_reader.sv
// Drives an ADC sequencer and sample store over CSR buses, reading one pass
// of NUM_SLOTS samples per end-of-sequence interrupt into a streaming FIFO.
// Optional overrun counter: define ADC_READER_OVERRUN_CNT_EN.
module adc_sample_reader
    import adc_reader_pkg::*;
#(
    parameter int unsigned NUM_SLOTS  = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [2:0]  SEQ_MODE   = 3'd0
) (
    input  logic        clock_clk,
    input  logic        reset_sink_reset_n,
    input  logic        enable,
    output logic        sequencer_csr_address,
    output logic        sequencer_csr_write,
    output logic [31:0] sequencer_csr_writedata,
    output logic [6:0]  sample_store_csr_address,
    output logic        sample_store_csr_read,
    output logic        sample_store_csr_write,
    output logic [31:0] sample_store_csr_writedata,
    input  logic [31:0] sample_store_csr_readdata,
    input  logic        sample_store_irq_irq,
    output logic [11:0] sample_data,
    output logic [5:0]  sample_slot,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic [15:0] overrun_count
);

    localparam int unsigned   CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] MAX_FILL  = CW'(FIFO_DEPTH - NUM_SLOTS);
    localparam logic [5:0]    LAST_SLOT = 6'(NUM_SLOTS - 1);

    adc_state_e    state_q, state_d;
    logic [5:0]    slot_q, slot_d;
    logic          push;
    logic          fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count;
    logic          space_ok;
    sample_entry_t push_entry, head_entry;
    logic          unused_rd;

    assign unused_rd  = ^{sample_store_csr_readdata[31:12], fifo_full};
    assign space_ok   = (fifo_count <= MAX_FILL);
    assign push_entry = '{slot: slot_q, data: sample_store_csr_readdata[11:0]};

    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    // Bus outputs decode straight from the state register so reset clears them immediately.
    always_comb begin
        state_d                    = state_q;
        slot_d                     = slot_q;
        push                       = 1'b0;
        sequencer_csr_address      = SEQ_CMD;
        sequencer_csr_write        = 1'b0;
        sequencer_csr_writedata    = '0;
        sample_store_csr_address   = '0;
        sample_store_csr_read      = 1'b0;
        sample_store_csr_write     = 1'b0;
        sample_store_csr_writedata = '0;
        case (state_q)
            ST_IDLE: if (enable) state_d = ST_START;
            ST_START: begin
                sequencer_csr_write     = 1'b1;
                sequencer_csr_writedata = {28'd0, SEQ_MODE, 1'b1};
                state_d                 = ST_ENIRQ;
            end
            ST_ENIRQ: begin
                sample_store_csr_write     = 1'b1;
                sample_store_csr_address   = IER;
                sample_store_csr_writedata = 32'd1;
                state_d                    = ST_WAIT_IRQ;
            end
            ST_WAIT_IRQ: begin
                if (!enable) begin
                    state_d = ST_STOP;
                end else if (sample_store_irq_irq) begin
                    if (space_ok) begin
                        slot_d  = '0;
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_READ: begin
                sample_store_csr_read    = 1'b1;
                sample_store_csr_address = {1'b0, slot_q};
                state_d                  = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                push = 1'b1;
                if (slot_q == LAST_SLOT) begin
                    state_d = ST_CLEAR;
                end else begin
                    slot_d  = slot_q + 6'd1;
                    state_d = ST_READ;
                end
            end
            ST_CLEAR: begin
                sample_store_csr_write     = 1'b1;
                sample_store_csr_address   = ISR;
                sample_store_csr_writedata = 32'd1;
                state_d                    = ST_WAIT_IRQ;
            end
            ST_STOP: begin
                sequencer_csr_write = 1'b1;
                state_d             = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    adc_reader_fifo #(
        .WIDTH ($bits(sample_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clock_clk),
        .rst_ni      (reset_sink_reset_n),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (sample_valid && sample_ready),
        .pop_data_o  (head_entry),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign sample_valid = !fifo_empty;
    assign sample_data  = head_entry.data;
    assign sample_slot  = head_entry.slot;

`ifdef ADC_READER_OVERRUN_CNT_EN
    logic        overrun_evt;
    logic [15:0] overrun_q;

    assign overrun_evt = (state_q == ST_WAIT_IRQ) && enable && sample_store_irq_irq && !space_ok;

    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n)                     overrun_q <= '0;
        else if (overrun_evt && (overrun_q != '1))   overrun_q <= overrun_q + 16'd1;
    end

    assign overrun_count = overrun_q;
`else
    assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_adc_sample_reader.sv
// Scoreboard bench for adc_sample_reader: expected bus cycles and stream
// samples are queued as stimulus is issued and popped by negedge monitors.
module tb_adc_sample_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        seq_addr, seq_wr;
    logic [31:0] seq_wd;
    logic [6:0]  st_addr;
    logic        st_rd, st_wr;
    logic [31:0] st_wd;
    logic [31:0] rdata = 32'd0;
    logic        irq;
    logic [11:0] s_data;
    logic [5:0]  s_slot;
    logic        s_valid, s_ready;
    logic [15:0] ovr;

    int errors = 0;
    int checks = 0;
    int base   = 0;

    typedef struct {
        int          kind;   // 0 seq write, 1 store write, 2 store read
        logic [6:0]  addr;
        logic [31:0] data;
    } bus_t;
    typedef struct {
        logic [5:0]  slot;
        logic [11:0] data;
    } smp_t;

    bus_t bus_q[$];
    smp_t smp_q[$];

    always #5 clk = ~clk;

    adc_sample_reader #(
        .NUM_SLOTS  (8),
        .FIFO_DEPTH (16),
        .SEQ_MODE   (3'd0)
    ) dut (
        .clock_clk                  (clk),
        .reset_sink_reset_n         (rst_n),
        .enable                     (en),
        .sequencer_csr_address      (seq_addr),
        .sequencer_csr_write        (seq_wr),
        .sequencer_csr_writedata    (seq_wd),
        .sample_store_csr_address   (st_addr),
        .sample_store_csr_read      (st_rd),
        .sample_store_csr_write     (st_wr),
        .sample_store_csr_writedata (st_wd),
        .sample_store_csr_readdata  (rdata),
        .sample_store_irq_irq       (irq),
        .sample_data                (s_data),
        .sample_slot                (s_slot),
        .sample_valid               (s_valid),
        .sample_ready               (s_ready),
        .overrun_count              (ovr)
    );

    // Sample-store model: fixed read latency of one cycle, junk in the upper bits.
    always @(posedge clk)
        if (st_rd) rdata <= 32'hABC0_0000 | (32'(base) << 8) | (32'(st_addr) << 4) | 32'h5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input int kind, input logic [6:0] addr, input logic [31:0] data);
        bus_t e;
        if (bus_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bus_unexpected: got kind=%0d addr=0x%0h data=0x%0h expected none", kind, addr, data);
        end else begin
            e = bus_q.pop_front();
            check("bus_kind", 32'(kind), 32'(e.kind));
            check("bus_addr", 32'(addr), 32'(e.addr));
            if (kind != 2) check("bus_data", data, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (st_rd && (st_wr || seq_wr)) check("rd_wr_overlap", 32'd1, 32'd0);
            if (seq_wr) chk_bus(0, {6'd0, seq_addr}, seq_wd);
            if (st_wr)  chk_bus(1, st_addr, st_wd);
            if (st_rd)  chk_bus(2, st_addr, 32'd0);
        end
    end

    always @(negedge clk) begin
        smp_t e;
        if (rst_n === 1'b1 && s_valid && s_ready) begin
            if (smp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stream_unexpected: got slot=%0d data=0x%0h expected none", s_slot, s_data);
            end else begin
                e = smp_q.pop_front();
                check("stream_slot", 32'(s_slot), 32'(e.slot));
                check("stream_data", 32'(s_data), 32'(e.data));
            end
        end
    end

    task automatic exp_start();
        bus_q.push_back('{0, 7'h00, 32'h1});
        bus_q.push_back('{1, 7'h40, 32'h1});
    endtask

    task automatic exp_pass(input int b, input int nreads, input bit isr, input bit stream);
        for (int s = 0; s < nreads; s++) begin
            bus_q.push_back('{2, 7'(s), 32'd0});
            if (stream) smp_q.push_back('{6'(s), 12'(b * 256 + s * 16 + 5)});
        end
        if (isr) bus_q.push_back('{1, 7'h41, 32'h1});
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while ((bus_q.size() != 0 || smp_q.size() != 0) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_drain_timeout"}, 32'(bus_q.size() + smp_q.size()), 32'd0);
    endtask

    // Holds irq until the ISR clear is seen, optionally dropping enable mid-pass.
    task automatic irq_service(input int disable_at);
        bit seen = 1'b0;
        irq = 1'b1;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (st_rd && disable_at >= 0 && st_addr == 7'(disable_at)) en = 1'b0;
            if (st_wr && st_addr == 7'h41) seen = 1'b1;
        end
        irq = 1'b0;
        check("irq_isr_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        bit hit;
        rst_n   = 1'b0;
        en      = 1'b0;
        irq     = 1'b0;
        s_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_strobes", {29'd0, seq_wr, st_wr, st_rd}, 32'd0);
        check("rst_valid", 32'(s_valid), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        exp_start();
        en = 1'b1;
        drain("start");

        base    = 0;
        s_ready = 1'b1;
        exp_pass(0, 8, 1'b1, 1'b1);
        irq_service(-1);
        drain("pass0");

        s_ready = 1'b0;
        base    = 1;
        exp_pass(1, 8, 1'b1, 1'b1);
        irq_service(-1);
        drain_bus_only();
        base = 2;
        exp_pass(2, 8, 1'b1, 1'b1);
        irq_service(-1);
        drain_bus_only();
        check("full_valid", 32'(s_valid), 32'd1);
        check("stall_data", 32'(s_data), 32'h105);
        exp_pass(3, 0, 1'b1, 1'b0);
        irq_service(-1);
        drain_bus_only();
`ifdef ADC_READER_OVERRUN_CNT_EN
        check("overrun_cnt", 32'(ovr), 32'd1);
`else
        check("overrun_cnt", 32'(ovr), 32'd0);
`endif
        check("stall_data_hold", 32'(s_data), 32'h105);
        s_ready = 1'b1;
        drain("overrun");

        base = 4;
        exp_pass(4, 8, 1'b1, 1'b1);
        bus_q.push_back('{0, 7'h00, 32'h0});
        irq_service(3);
        drain("stop");
        repeat (10) @(negedge clk);
        check("idle_quiet", 32'(bus_q.size()), 32'd0);

        exp_start();
        en = 1'b1;
        drain("restart");

        s_ready = 1'b0;
        base    = 5;
        exp_pass(5, 6, 1'b0, 1'b0);
        irq = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            if (st_rd && st_addr == 7'd5) hit = 1'b1;
        end
        check("slot5_read_seen", 32'(hit), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_seq", {seq_wr, seq_addr, seq_wd[29:0]}, 32'd0);
        check("arst_store", {st_rd, st_wr, st_addr, st_wd[22:0]}, 32'd0);
        check("arst_stream", {13'd0, s_valid, s_slot, s_data}, 32'd0);
        check("arst_ovr", 32'(ovr), 32'd0);
        irq = 1'b0;
        en  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        s_ready = 1'b1;
        repeat (12) @(negedge clk);
        check("post_rst_quiet", 32'(bus_q.size() + smp_q.size()), 32'd0);
        exp_start();
        en = 1'b1;
        drain("post_rst_start");

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic drain_bus_only();
        int cyc = 0;
        while (bus_q.size() != 0 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("bus_drain_timeout", 32'(bus_q.size()), 32'd0);
    endtask

endmodule
